// File: rtl/game_sequencer.sv
// Tile-flip memory game sequencer: show a target 4x4 pattern, then let the player rebuild it before time runs out.
// Optional macro TILE_FLIP_NEIGHBOR_EN makes each flip also toggle the orthogonal neighbours of the chosen tile.
module game_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  level,
  input  logic [15:0] pattern,
  input  logic        tick,
  input  logic        flip_valid,
  input  logic [3:0]  flip_idx,
  input  logic        retry,
  output logic [2:0]  state,
  output logic        show_en,
  output logic [15:0] board,
  output logic [5:0]  time_left,
  output logic [7:0]  moves,
  output logic        win,
  output logic        lose
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SHOW = 3'd1,
    PLAY = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_t;

  state_t      state_reg;
  logic        show_en_reg;
  logic        win_reg;
  logic        lose_reg;
  logic [15:0] board_reg;
  logic [5:0]  time_left_reg;
  logic [7:0]  moves_reg;
  logic [1:0]  level_reg;
  logic [15:0] pattern_reg;
  logic [4:0]  show_cnt_reg;
  logic [15:0] flip_mask;

  function automatic logic [4:0] show_load(input logic [1:0] lvl);
    case (lvl)
      2'd0:    show_load = 5'd16;
      2'd1:    show_load = 5'd12;
      2'd2:    show_load = 5'd8;
      default: show_load = 5'd4;
    endcase
  endfunction

  function automatic logic [5:0] time_load(input logic [1:0] lvl);
    case (lvl)
      2'd0:    time_load = 6'd60;
      2'd1:    time_load = 6'd50;
      2'd2:    time_load = 6'd40;
      default: time_load = 6'd30;
    endcase
  endfunction

  // Per-tile toggle decode; neighbour terms are pruned at the grid edges so there is no wrap-around.
  for (genvar gi = 0; gi < 16; gi++) begin : g_mask
`ifdef TILE_FLIP_NEIGHBOR_EN
    localparam bit HAS_UP    = (gi >= 4);
    localparam bit HAS_DOWN  = (gi < 12);
    localparam bit HAS_LEFT  = ((gi % 4) != 0);
    localparam bit HAS_RIGHT = ((gi % 4) != 3);
    assign flip_mask[gi] = (int'(flip_idx) == gi)
                         | (HAS_UP    && (int'(flip_idx) == gi - 4))
                         | (HAS_DOWN  && (int'(flip_idx) == gi + 4))
                         | (HAS_LEFT  && (int'(flip_idx) == gi - 1))
                         | (HAS_RIGHT && (int'(flip_idx) == gi + 1));
`else
    assign flip_mask[gi] = (int'(flip_idx) == gi);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      show_en_reg   <= 1'b0;
      win_reg       <= 1'b0;
      lose_reg      <= 1'b0;
      board_reg     <= '0;
      time_left_reg <= '0;
      moves_reg     <= '0;
      level_reg     <= '0;
      pattern_reg   <= '0;
      show_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            level_reg    <= level;
            pattern_reg  <= pattern;
            show_cnt_reg <= show_load(level);
            state_reg    <= SHOW;
            show_en_reg  <= 1'b1;
          end
        end
        SHOW: begin
          if (tick) begin
            show_cnt_reg <= show_cnt_reg - 5'd1;
            if (show_cnt_reg == 5'd1) begin
              state_reg     <= PLAY;
              show_en_reg   <= 1'b0;
              board_reg     <= '0;
              moves_reg     <= '0;
              time_left_reg <= time_load(level_reg);
            end
          end
        end
        PLAY: begin
          // A solved board wins outright: the flip and tick of this cycle are dropped.
          if (board_reg == pattern_reg) begin
            state_reg <= WIN;
            win_reg   <= 1'b1;
          end else begin
            if (flip_valid) begin
              board_reg <= board_reg ^ flip_mask;
              moves_reg <= moves_reg + {7'd0, (moves_reg != 8'hFF)};
            end
            if (tick) begin
              time_left_reg <= time_left_reg - 6'd1;
              if (time_left_reg == 6'd1) begin
                state_reg <= LOSE;
                lose_reg  <= 1'b1;
              end
            end
          end
        end
        WIN, LOSE: begin
          if (retry) begin
            state_reg    <= SHOW;
            show_en_reg  <= 1'b1;
            win_reg      <= 1'b0;
            lose_reg     <= 1'b0;
            show_cnt_reg <= show_load(level_reg);
          end
        end
        default: begin
          state_reg   <= IDLE;
          show_en_reg <= 1'b0;
          win_reg     <= 1'b0;
          lose_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_reg;
  assign show_en   = show_en_reg;
  assign board     = board_reg;
  assign time_left = time_left_reg;
  assign moves     = moves_reg;
  assign win       = win_reg;
  assign lose      = lose_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a reference model tracks every cycle and directed scenarios pin literal values.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  level = 2'd0;
  logic [15:0] pattern = 16'h0;
  logic        tick = 1'b0;
  logic        flip_valid = 1'b0;
  logic [3:0]  flip_idx = 4'd0;
  logic        retry = 1'b0;
  logic [2:0]  state;
  logic        show_en;
  logic [15:0] board;
  logic [5:0]  time_left;
  logic [7:0]  moves;
  logic        win;
  logic        lose;

  int checks = 0;
  int failures = 0;

  game_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .level(level), .pattern(pattern),
    .tick(tick), .flip_valid(flip_valid), .flip_idx(flip_idx), .retry(retry),
    .state(state), .show_en(show_en), .board(board), .time_left(time_left),
    .moves(moves), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Tiles affected by a flip, worked out from row/column geometry.
  function automatic int flip_set(input int idx);
    int m;
    int r;
    int c;
    m = 1 << idx;
    r = idx / 4;
    c = idx % 4;
`ifdef TILE_FLIP_NEIGHBOR_EN
    if (r > 0) m = m | (1 << (idx - 4));
    if (r < 3) m = m | (1 << (idx + 4));
    if (c > 0) m = m | (1 << (idx - 1));
    if (c < 3) m = m | (1 << (idx + 1));
`endif
    return m;
  endfunction

  // Reference model: phase 0 idle, 1 showing, 2 playing, 3 won, 4 lost.
  int m_phase = 0;
  int m_show = 0;
  int m_time = 0;
  int m_moves = 0;
  int m_board = 0;
  int m_lvl = 0;
  int m_pat = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_show = 0; m_time = 0; m_moves = 0;
      m_board = 0; m_lvl = 0; m_pat = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_lvl = int'(level);
        m_pat = int'(pattern);
        m_show = 16 - 4 * m_lvl;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (tick) begin
        m_show = m_show - 1;
        if (m_show == 0) begin
          m_phase = 2;
          m_board = 0;
          m_moves = 0;
          m_time = 60 - 10 * m_lvl;
        end
      end
    end else if (m_phase == 2) begin
      if (m_board == m_pat) begin
        m_phase = 3;
      end else begin
        if (flip_valid) begin
          m_board = m_board ^ flip_set(int'(flip_idx));
          if (m_moves < 255) m_moves = m_moves + 1;
        end
        if (tick) begin
          m_time = m_time - 1;
          if (m_time == 0) m_phase = 4;
        end
      end
    end else begin
      if (retry) begin
        m_phase = 1;
        m_show = 16 - 4 * m_lvl;
      end
    end
  end

  always @(negedge clk) begin
    check("state", int'(state), m_phase);
    check("show_en", int'(show_en), int'(m_phase == 1));
    check("win", int'(win), int'(m_phase == 3));
    check("lose", int'(lose), int'(m_phase == 4));
    check("board", int'(board), m_board);
    check("time_left", int'(time_left), m_time);
    check("moves", int'(moves), m_moves);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic start_game(input logic [1:0] lvl, input logic [15:0] pat);
    level = lvl;
    pattern = pat;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_show(output int n);
    n = 0;
    while (state == 3'd1 && n < 40) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      n++;
    end
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) begin
      tick = 1'b1;
      cycle();
    end
    tick = 1'b0;
  endtask

  task automatic flip(input logic [3:0] idx);
    flip_valid = 1'b1;
    flip_idx = idx;
    cycle();
    flip_valid = 1'b0;
  endtask

  int n;
  logic [15:0] pat30;

  initial begin
    check("reset_state", int'(state), 0);
    do_reset();

    // Level 2, single-tile target.
    start_game(2'd2, 16'h0001);
    check("s1_state_show", int'(state), 1);
    check("s1_show_en", int'(show_en), 1);
    run_show(n);
    $display("scenario level2 show ticks=%0d", n);
    check("s1_show_ticks", n, 8);
    check("s1_state_play", int'(state), 2);
    check("s1_time_left", int'(time_left), 40);
    check("s1_board", int'(board), 0);
`ifndef TILE_FLIP_NEIGHBOR_EN
    flip(4'd0);
    check("s2_board", int'(board), 16'h0001);
    check("s2_moves", int'(moves), 1);
    cycle();
    check("s2_state_win", int'(state), 3);
    check("s2_win", int'(win), 1);
    start_game(2'd0, 16'h0);
    check("s2_start_ignored", int'(state), 3);
`else
    flip(4'd5);
    check("s28_board_idx5", int'(board), 16'h0272);
    flip(4'd0);
    check("s28_board_idx0", int'(board), 16'h0261);
`endif

    // Level 3 timeout, retry and simultaneous tick+flip.
    do_reset();
    start_game(2'd3, 16'h8000);
    run_show(n);
    check("s3_show_ticks", n, 4);
    retry = 1'b1;
    cycle();
    retry = 1'b0;
    check("s3_retry_ignored", int'(state), 2);
    ticks(29);
    check("s3_time_one", int'(time_left), 1);
    ticks(1);
    $display("scenario level3 timeout state=%0d time_left=%0d", state, time_left);
    check("s3_time_zero", int'(time_left), 0);
    check("s3_state_lose", int'(state), 4);
    check("s3_lose", int'(lose), 1);
    flip(4'd2);
    check("s3_frozen_board", int'(board), 0);
    retry = 1'b1;
    cycle();
    retry = 1'b0;
    check("s3_retry_show", int'(state), 1);
    run_show(n);
    check("s3_retry_ticks", n, 4);
    check("s3_time_reload", int'(time_left), 30);
    tick = 1'b1;
    flip(4'd3);
    tick = 1'b0;
    check("s22_moves", int'(moves), 1);
    check("s22_time", int'(time_left), 29);
`ifndef TILE_FLIP_NEIGHBOR_EN
    check("s22_board", int'(board), 16'h0008);
`else
    check("s22_board", int'(board), 16'h008C);
`endif

    // Asynchronous reset in the middle of PLAY.
    for (int i = 0; i < 6; i++) flip(4'd1);
    check("s29_moves", int'(moves), 7);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    $display("scenario async reset state=%0d moves=%0d", state, moves);
    check("s29_state", int'(state), 0);
    check("s29_moves_clr", int'(moves), 0);
    check("s29_board_clr", int'(board), 0);
    check("s29_time_clr", int'(time_left), 0);
    check("s29_flags", int'({show_en, win, lose}), 0);
    cycle();
    reset = 1'b0;
    cycle();

    // Board solved in the same cycle as the final tick.
`ifndef TILE_FLIP_NEIGHBOR_EN
    pat30 = 16'h0001;
`else
    pat30 = 16'h0013;
`endif
    start_game(2'd3, pat30);
    run_show(n);
    ticks(29);
    flip(4'd0);
    check("s30_board", int'(board), int'(pat30));
    ticks(1);
    $display("scenario win-vs-timeout state=%0d time_left=%0d", state, time_left);
    check("s30_state_win", int'(state), 3);
    check("s30_time_frozen", int'(time_left), 1);

    // All-zero target wins on the first PLAY cycle.
    do_reset();
    start_game(2'd0, 16'h0000);
    run_show(n);
    check("s18_show_ticks", n, 16);
    check("s18_time", int'(time_left), 60);
    cycle();
    check("s18_state_win", int'(state), 3);

    // Move counter saturation.
    do_reset();
    start_game(2'd0, 16'h8000);
    run_show(n);
    for (int i = 0; i < 260; i++) flip(4'd1);
    $display("scenario saturation moves=%0d", moves);
    check("sat_moves", int'(moves), 255);

    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
